// File: rtl/piece_input_ctrl.sv
// Push-button conditioner for the moving-piece stage: synchronise, debounce and
// resolve the up/down buttons, then emit one command per press with hold-to-repeat.
module piece_input_ctrl #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 15,
  parameter int REPEAT_RATE    = 1,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic       clk_refresh,
  input  logic       reset,
  input  logic       btn_down_raw,
  input  logic       btn_up_raw,
  output logic [1:0] controller
);

  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [1:0]       IDLE_LVL   = {2{BTN_ACTIVE_LOW}};

  // Direction codes line up with the controller bits (bit1 = down, bit0 = up).
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_DELAY,
    S_REPEAT
  } state_e;

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       pressed;
  logic [1:0]       db_q, db_d;
  logic [DB_W-1:0]  db_cnt_q [2];
  logic [DB_W-1:0]  db_cnt_d [2];
  logic [1:0]       rise;
  dir_e             last_q, last_d;
  dir_e             dir_now;
  dir_e             dir_q, dir_d;
  state_e           state_q, state_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ctrl_q, ctrl_d;

  // Synchroniser, index 1 = down, index 0 = up.
  always_comb begin
    sync1_d = {btn_down_raw, btn_up_raw};
    sync2_d = sync1_q;
    pressed = sync2_q ^ IDLE_LVL;
  end

  // Debounce: accept a new level only after DEBOUNCE_TICKS consecutive differing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (pressed[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = pressed[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Last-pressed tracking; a tie on the same edge leaves neither as the winner.
  always_comb begin
    rise   = db_d & ~db_q;
    last_d = last_q;
    case (rise)
      2'b01:   last_d = DIR_UP;
      2'b10:   last_d = DIR_DOWN;
      2'b11:   last_d = DIR_NONE;
      default: last_d = last_q;
    endcase
    case (db_q)
      2'b01:   dir_now = DIR_UP;
      2'b10:   dir_now = DIR_DOWN;
      2'b11:   dir_now = last_q;
      default: dir_now = DIR_NONE;
    endcase
  end

  // Any change of direction while engaged drops to IDLE first, which forces a
  // 00 tick between opposite commands.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (dir_now != DIR_NONE) begin
        state_d = S_FIRE;
        dir_d   = dir_now;
      end
    end else if (dir_now != dir_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_FIRE: begin
          cnt_d   = '0;
          state_d = (REPEAT_DELAY == 0) ? S_REPEAT : S_DELAY;
        end
        S_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            state_d = S_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + RPT_W'(1);
          end
        end
        S_REPEAT: cnt_d = (cnt_q == RATE_LAST) ? '0 : cnt_q + RPT_W'(1);
        default:  state_d = S_IDLE;
      endcase
    end

    ctrl_d = 2'b00;
    case (state_d)
      S_FIRE:   ctrl_d = dir_d;
      S_REPEAT: ctrl_d = (cnt_d == '0) ? dir_d : 2'b00;
      default:  ctrl_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk_refresh or posedge reset) begin
    if (reset) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      db_q    <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      last_q  <= DIR_NONE;
      dir_q   <= DIR_NONE;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      last_q  <= last_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign controller = ctrl_q;

endmodule

// File: tb/tb_piece_input_ctrl.sv
// Bench for piece_input_ctrl: vector table, hand-written corner sequences and a
// randomized run against an event-level reference model.
module tb_piece_input_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_down = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down_n, btn_up_n;
  logic [1:0] ctrl_a, ctrl_c, ctrl_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign btn_down_n = ~btn_down;
  assign btn_up_n   = ~btn_up;

  piece_input_ctrl #(.DEBOUNCE_TICKS(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .BTN_ACTIVE_LOW(1'b0))
    u_dut_a (.clk_refresh(clk), .reset(reset), .btn_down_raw(btn_down), .btn_up_raw(btn_up),
             .controller(ctrl_a));

  piece_input_ctrl #(.DEBOUNCE_TICKS(4), .REPEAT_DELAY(0), .REPEAT_RATE(1), .BTN_ACTIVE_LOW(1'b0))
    u_dut_c (.clk_refresh(clk), .reset(reset), .btn_down_raw(btn_down), .btn_up_raw(btn_up),
             .controller(ctrl_c));

  piece_input_ctrl #(.DEBOUNCE_TICKS(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .BTN_ACTIVE_LOW(1'b1))
    u_dut_n (.clk_refresh(clk), .reset(reset), .btn_down_raw(btn_down_n), .btn_up_raw(btn_up_n),
             .controller(ctrl_n));

  typedef struct {
    logic       d;
    logic       u;
    logic [1:0] ea;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_down = 1'b0;
    btn_up   = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_a", ctrl_a, 2'b00);
    check("reset_c", ctrl_c, 2'b00);
    check("reset_n", ctrl_n, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic add_vec(input logic d, input logic u, input logic [1:0] ea,
                         input logic [1:0] ec, input int n);
    vec_t v;
    v.d = d; v.u = u; v.ea = ea; v.ec = ec;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  // Reference model: raw history, run lengths of the synchronised samples, and
  // per-configuration engagement with the time of the last fire.
  localparam int DT = 4;
  int         rd_p[2] = '{3, 0};
  int         rr_p[2] = '{2, 1};
  logic [1:0] m_r1, m_r2, m_sval, m_db, m_last;
  int         m_run[2];
  bit         m_eng[2];
  logic [1:0] m_cur[2];
  int         m_fire[2];
  int         m_t;
  logic [1:0] exp_o[2];

  task automatic model_reset();
    m_r1 = 2'b00; m_r2 = 2'b00; m_sval = 2'b00; m_db = 2'b00; m_last = 2'b00;
    m_t = 0;
    for (int m = 0; m < 2; m++) begin
      m_run[m] = 0; m_eng[m] = 1'b0; m_cur[m] = 2'b00; m_fire[m] = 0; exp_o[m] = 2'b00;
    end
  endtask

  task automatic model_step();
    logic [1:0] dir, s, ndb, rise;
    int         age;
    dir = (m_db == 2'b11) ? m_last : m_db;
    for (int m = 0; m < 2; m++) begin
      if (dir == 2'b00) begin
        m_eng[m] = 1'b0;
        exp_o[m] = 2'b00;
      end else if (!m_eng[m]) begin
        m_eng[m] = 1'b1; m_cur[m] = dir; m_fire[m] = m_t; exp_o[m] = dir;
      end else if (dir != m_cur[m]) begin
        m_eng[m] = 1'b0;
        exp_o[m] = 2'b00;
      end else begin
        age = m_t - m_fire[m];
        if (age <= rd_p[m]) exp_o[m] = 2'b00;
        else exp_o[m] = (((age - 1 - rd_p[m]) % rr_p[m]) == 0) ? m_cur[m] : 2'b00;
      end
    end
    s   = m_r2;
    ndb = m_db;
    for (int b = 0; b < 2; b++) begin
      if (s[b] == m_sval[b]) m_run[b]++;
      else begin
        m_sval[b] = s[b];
        m_run[b]  = 1;
      end
      if (s[b] != m_db[b] && m_run[b] >= DT) ndb[b] = s[b];
    end
    rise = ndb & ~m_db;
    if (rise == 2'b11) m_last = 2'b00;
    else if (rise != 2'b00) m_last = rise;
    m_db = ndb;
    m_r2 = m_r1;
    m_r1 = {btn_down, btn_up};
    m_t++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Press-and-release of down: 20 held ticks, then released.
    add_vec(1'b1, 1'b0, 2'b00, 2'b00, 6);
    add_vec(1'b1, 1'b0, 2'b10, 2'b10, 1);
    add_vec(1'b1, 1'b0, 2'b00, 2'b10, 3);
    for (int k = 10; k < 20; k++) add_vec(1'b1, 1'b0, (k % 2 == 0) ? 2'b10 : 2'b00, 2'b10, 1);
    for (int k = 20; k < 26; k++) add_vec(1'b0, 1'b0, (k % 2 == 0) ? 2'b10 : 2'b00, 2'b10, 1);
    add_vec(1'b0, 1'b0, 2'b00, 2'b00, 8);
    // 3-tick up glitch is rejected.
    add_vec(1'b0, 1'b1, 2'b00, 2'b00, 3);
    add_vec(1'b0, 1'b0, 2'b00, 2'b00, 8);
    // 4-tick up pulse gives a single command on the delayed configuration.
    add_vec(1'b0, 1'b1, 2'b00, 2'b00, 4);
    add_vec(1'b0, 1'b0, 2'b00, 2'b00, 2);
    add_vec(1'b0, 1'b0, 2'b01, 2'b01, 1);
    add_vec(1'b0, 1'b0, 2'b00, 2'b01, 3);
    add_vec(1'b0, 1'b0, 2'b00, 2'b00, 4);

    do_reset();
    foreach (tbl[i]) begin
      btn_down = tbl[i].d;
      btn_up   = tbl[i].u;
      tick();
      check($sformatf("tbl_a[%0d]", i), ctrl_a, tbl[i].ea);
      check($sformatf("tbl_c[%0d]", i), ctrl_c, tbl[i].ec);
      check($sformatf("tbl_n[%0d]", i), ctrl_n, tbl[i].ea);
    end

    // Last-pressed wins, and the earlier button resumes after release.
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      btn_up   = 1'b1;
      btn_down = (e >= 10 && e < 30);
      tick();
      case (e)
        15: check("last_e15", ctrl_a, 2'b00);
        16: check("last_gap_dn", ctrl_a, 2'b00);
        17: check("last_fire_dn", ctrl_a, 2'b10);
        35: check("last_e35", ctrl_a, 2'b10);
        36: check("last_gap_up", ctrl_a, 2'b00);
        37: check("last_fire_up", ctrl_a, 2'b01);
        default: ;
      endcase
    end

    // Simultaneous press stays silent until up is released.
    do_reset();
    for (int e = 0; e <= 27; e++) begin
      btn_down = 1'b1;
      btn_up   = (e < 20);
      tick();
      if (e <= 25) check($sformatf("simul_e%0d", e), ctrl_a, 2'b00);
      else if (e == 26) check("simul_fire", ctrl_a, 2'b10);
      else check("simul_after", ctrl_a, 2'b00);
    end

    // Reset during repeat, then a full re-debounce.
    do_reset();
    for (int e = 0; e <= 14; e++) begin
      btn_down = 1'b1;
      tick();
    end
    check("mid_repeat", ctrl_a, 2'b10);
    #1 reset = 1'b1;
    #1;
    check("rst_async_a", ctrl_a, 2'b00);
    check("rst_async_c", ctrl_c, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check("rst_wait_a", ctrl_a, 2'b00);
      if (e == 6) begin
        check("rst_refire_a", ctrl_a, 2'b10);
        check("rst_refire_c", ctrl_c, 2'b10);
        check("rst_refire_n", ctrl_n, 2'b10);
      end
    end

    // Randomized hold/release patterns against the reference model.
    do_reset();
    model_reset();
    for (int seg = 0; seg < 250; seg++) begin
      logic [1:0] val;
      int         len;
      val = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 8));
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("rnd_rst_a", ctrl_a, 2'b00);
        check("rnd_rst_n", ctrl_n, 2'b00);
        @(posedge clk);
        #2 reset = 1'b0;
      end
      for (int k = 0; k < len; k++) begin
        {btn_down, btn_up} = val;
        @(posedge clk);
        model_step();
        #1;
        check("rnd_a", ctrl_a, exp_o[0]);
        check("rnd_c", ctrl_c, exp_o[1]);
        check("rnd_n", ctrl_n, exp_o[0]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
